// File: rtl/mem_arbiter.sv
// mem_arbiter: joins the core's fetch port and its load/store port to the
// program ROM and the data RAM. It decodes one flat byte address space and
// arbitrates between the two requesters. It runs one access at a time.
// Byte-masked stores become read-modify-write, because the RAM only takes
// whole words.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   if_req_*/if_addr         fetch request (valid/ready handshake)
//   if_resp_valid/rdata/err  one-cycle fetch response
//   d_req_*/d_addr/d_we/d_be/d_wdata  load/store request
//   d_resp_valid/rdata/err   one-cycle data response
//   rom_addr/rom_rdata       ROM byte address, combinational read word
//   ram_addr/ram_w_en/ram_wdata/ram_rdata  RAM byte offset, write strobe, data
module mem_arbiter #(
  parameter int unsigned ROM_SZ   = 16384,
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter int unsigned RAM_SZ   = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_w_en,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RMW_RD, S_WRITE, S_RESP} state_t;

  localparam logic [32:0] ROM_END = 33'(ROM_SZ);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_SZ);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;     // 1: last grant went to the data port
  logic        req_d_q, req_d_d;       // requester of the access in flight
  logic        in_rom_q, in_rom_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_w_en_q, ram_w_en_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        if_resp_valid_q, if_resp_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_resp_valid_q, d_resp_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        idle;
  logic [31:0] req_addr;
  logic        req_we, in_rom, in_ram, req_err;
  logic [31:0] merged;

  // Grant only in IDLE. On a tie, the side that was not served last wins.
  assign idle         = (state_q == S_IDLE) && !rst;
  assign if_req_ready = idle && if_req_valid && (!d_req_valid || last_d_q);
  assign d_req_ready  = idle && d_req_valid && (!if_req_valid || !last_d_q);

  assign req_addr = d_req_ready ? d_addr : if_addr;
  assign req_we   = d_req_ready && d_we;

  // The end checks are 33 bits wide so that addr+3 cannot wrap past zero.
  assign in_rom  = ({1'b0, req_addr} + 33'd3) < ROM_END;
  assign in_ram  = (req_addr >= RAM_BASE) && (({1'b0, req_addr} + 33'd3) < RAM_END);
  assign req_err = (req_addr[1:0] != 2'b00) || (!in_rom && !in_ram) || (req_we && in_rom);

  always_comb begin
    merged = ram_rdata;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  always_comb begin
    state_d         = state_q;
    last_d_d        = last_d_q;
    req_d_d         = req_d_q;
    in_rom_d        = in_rom_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    rom_addr_d      = rom_addr_q;
    ram_addr_d      = ram_addr_q;
    ram_w_en_d      = 1'b0;
    ram_wdata_d     = ram_wdata_q;
    if_resp_valid_d = 1'b0;
    if_rdata_d      = if_rdata_q;
    if_err_d        = if_err_q;
    d_resp_valid_d  = 1'b0;
    d_rdata_d       = d_rdata_q;
    d_err_d         = d_err_q;

    case (state_q)
      S_IDLE: begin
        if (if_req_ready || d_req_ready) begin
          last_d_d = d_req_ready;
          req_d_d  = d_req_ready;
          in_rom_d = in_rom;
          be_d     = d_be;
          wdata_d  = d_wdata;
          if (req_err || (req_we && d_be == 4'h0)) begin
            // Errors and empty stores skip the memories and answer next cycle.
            state_d = S_RESP;
            if (d_req_ready) begin
              d_resp_valid_d = 1'b1;
              d_rdata_d      = 32'h0;
              d_err_d        = req_err;
            end else begin
              if_resp_valid_d = 1'b1;
              if_rdata_d      = 32'h0;
              if_err_d        = 1'b1;
            end
          end else if (!req_we) begin
            state_d = S_ACCESS;
            if (in_rom) rom_addr_d = req_addr;
            else        ram_addr_d = req_addr - RAM_BASE;
          end else if (d_be == 4'hF) begin
            state_d     = S_WRITE;
            ram_addr_d  = req_addr - RAM_BASE;
            ram_wdata_d = d_wdata;
            ram_w_en_d  = 1'b1;
          end else begin
            state_d    = S_RMW_RD;
            ram_addr_d = req_addr - RAM_BASE;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (req_d_q) begin
          d_resp_valid_d = 1'b1;
          d_rdata_d      = in_rom_q ? rom_rdata : ram_rdata;
          d_err_d        = 1'b0;
        end else begin
          if_resp_valid_d = 1'b1;
          if_rdata_d      = in_rom_q ? rom_rdata : ram_rdata;
          if_err_d        = 1'b0;
        end
      end
      S_RMW_RD: begin
        state_d     = S_WRITE;
        ram_wdata_d = merged;
        ram_w_en_d  = 1'b1;
      end
      S_WRITE: begin
        // Only the data port issues stores.
        state_d        = S_RESP;
        d_resp_valid_d = 1'b1;
        d_rdata_d      = 32'h0;
        d_err_d        = 1'b0;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_d_q        <= 1'b0;
      req_d_q         <= 1'b0;
      in_rom_q        <= 1'b0;
      be_q            <= 4'h0;
      wdata_q         <= 32'h0;
      rom_addr_q      <= 32'h0;
      ram_addr_q      <= 32'h0;
      ram_w_en_q      <= 1'b0;
      ram_wdata_q     <= 32'h0;
      if_resp_valid_q <= 1'b0;
      if_rdata_q      <= 32'h0;
      if_err_q        <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      d_rdata_q       <= 32'h0;
      d_err_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_d_q        <= last_d_d;
      req_d_q         <= req_d_d;
      in_rom_q        <= in_rom_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      rom_addr_q      <= rom_addr_d;
      ram_addr_q      <= ram_addr_d;
      ram_w_en_q      <= ram_w_en_d;
      ram_wdata_q     <= ram_wdata_d;
      if_resp_valid_q <= if_resp_valid_d;
      if_rdata_q      <= if_rdata_d;
      if_err_q        <= if_err_d;
      d_resp_valid_q  <= d_resp_valid_d;
      d_rdata_q       <= d_rdata_d;
      d_err_q         <= d_err_d;
    end
  end

  // Reset kills a write or response already staged in the output flops.
  assign ram_w_en      = ram_w_en_q && !rst;
  assign if_resp_valid = if_resp_valid_q && !rst;
  assign d_resp_valid  = d_resp_valid_q && !rst;
  assign rom_addr      = rom_addr_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign if_err        = if_err_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory models plus a response scoreboard and a
// RAM write-strobe scoreboard. Expected values come from a reference RAM image.
module tb_mem_arbiter;
  localparam logic [31:0] RAM_BASE = 32'h0001_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_resp_valid, if_err;
  logic [31:0] if_rdata;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic        d_resp_valid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] rom_addr, rom_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_w_en;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; bit chk_data; logic [31:0] rdata; bit err; int hs; int lat; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wexp_t;
  exp_t  sb[$];
  wexp_t wq[$];
  bit    gq[$];

  int nvec = 0, nerr = 0, cyc = 0;
  logic [31:0] ram_mem [0:2047];
  logic [31:0] exp_ram [0:2047];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  assign rom_rdata = rom_word(rom_addr);
  assign ram_rdata = ram_mem[ram_addr[12:2]];
  always @(posedge clk) if (ram_w_en) ram_mem[ram_addr[12:2]] <= ram_wdata;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_rom_f(input logic [31:0] a);
    return ({32'd0, a} + 64'd3) < 64'd16384;
  endfunction
  function automatic bit in_ram_f(input logic [31:0] a);
    return (a >= RAM_BASE) && (({32'd0, a} + 64'd3) < 64'h1_2000);
  endfunction

  // Called at the negedge of the handshake cycle.
  task automatic push_exp(input bit is_d, input logic [31:0] a, input bit we,
                          input logic [3:0] be, input logic [31:0] wd);
    exp_t e; wexp_t w; logic [31:0] m; int idx;
    bit st = is_d && we;
    e.is_d = is_d; e.hs = cyc; e.rdata = 32'h0;
    e.err = (a[1:0] != 2'b00) || !(in_rom_f(a) || in_ram_f(a)) || (st && in_rom_f(a));
    e.chk_data = e.err || !st;
    idx = 0;
    if (in_ram_f(a)) idx = int'((a - RAM_BASE) >> 2);
    if (e.err) e.lat = 1;
    else if (!st) begin
      e.lat = 2;
      e.rdata = in_rom_f(a) ? rom_word(a) : exp_ram[idx];
    end else if (be == 4'h0) e.lat = 1;
    else begin
      m = exp_ram[idx];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
      e.lat = (be == 4'hF) ? 2 : 3;
      w.cyc = cyc + e.lat - 1; w.addr = a - RAM_BASE; w.data = m;
      wq.push_back(w);
      exp_ram[idx] = m;
    end
    sb.push_back(e);
    gq.push_back(is_d);
  endtask

  task automatic drive(input bit is_d, input logic [31:0] a, input bit we,
                       input logic [3:0] be, input logic [31:0] wd);
    bit ok = 0;
    int n = 0;
    if (is_d) begin d_req_valid = 1; d_addr = a; d_we = we; d_be = be; d_wdata = wd; end
    else begin if_req_valid = 1; if_addr = a; end
    while (!ok && n < 100) begin
      @(negedge clk);
      if (is_d ? d_req_ready : if_req_ready) ok = 1; else n++;
    end
    chk(is_d ? "d_hs_timeout" : "if_hs_timeout", {31'b0, ok}, 32'd1);
    if (ok) push_exp(is_d, a, we, be, wd);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 0; else if_req_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); @(negedge clk);
    chk("rst_outs", {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, ram_w_en, if_err, d_err},
        32'd0);
    chk("rst_data", if_rdata | d_rdata | ram_addr | rom_addr | ram_wdata, 32'd0);
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < 20) begin @(posedge clk); n++; end
    #1;
    chk("drain", sb.size() + wq.size(), 32'd0);
  endtask

  // Monitor: mutually exclusive readies, response routing and latency, write strobes.
  always @(negedge clk) begin
    exp_t e; wexp_t w;
    chk("rdy_excl", {31'b0, if_req_ready & d_req_ready}, 32'd0);
    if (if_resp_valid || d_resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("resp_both", {31'b0, if_resp_valid & d_resp_valid}, 32'd0);
        chk("resp_port", {31'b0, d_resp_valid}, {31'b0, e.is_d});
        chk("resp_lat", cyc - e.hs, e.lat);
        chk("resp_err", {31'b0, e.is_d ? d_err : if_err}, {31'b0, e.err});
        if (e.chk_data) chk("resp_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
      end
    end
    if (ram_w_en) begin
      if (wq.size() == 0) chk("spurious_wen", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        chk("wen_cyc", cyc, w.cyc);
        chk("wen_addr", ram_addr, w.addr);
        chk("wen_data", ram_wdata, w.data);
      end
    end
  end

  initial begin
    bit g0, g1, g2, g3;
    int bad;
    for (int i = 0; i < 2048; i++) begin ram_mem[i] = 32'hACAC_ACAC; exp_ram[i] = 32'hACAC_ACAC; end
    #1;
    do_reset();

    // Fetch, full store and read-back, partial store.
    drive(0, 32'h0000_0010, 0, 4'h0, 32'h0);
    drive(1, 32'h0001_0004, 1, 4'hF, 32'hDEAD_BEEF);
    drive(1, 32'h0001_0004, 0, 4'h0, 32'h0);
    drive(1, 32'h0001_0008, 1, 4'b0010, 32'h0000_5500);
    drive(1, 32'h0001_0008, 0, 4'h0, 32'h0);
    drain();
    chk("rmw_word", ram_mem[2], 32'hACAC_55AC);

    // Arbitration with both ports requesting back to back.
    do_reset();
    gq.delete();
    fork
      begin drive(1, 32'h0001_0004, 0, 4'h0, 32'h0); drive(1, 32'h0001_0008, 0, 4'h0, 32'h0); end
      begin drive(0, 32'h0000_0020, 0, 4'h0, 32'h0); drive(0, 32'h0001_0004, 0, 4'h0, 32'h0); end
    join
    drain();
    chk("grant_cnt", gq.size(), 32'd4);
    if (gq.size() == 4) begin
      g0 = gq[0]; g1 = gq[1]; g2 = gq[2]; g3 = gq[3];
      chk("grant_order", {28'b0, g0, g1, g2, g3}, 32'b1010);
    end

    // Errors and region edges.
    drive(1, 32'h0000_0100, 1, 4'hF, 32'h1234_5678);
    drive(1, 32'h0001_0002, 0, 4'h0, 32'h0);
    drive(1, 32'h0001_2000, 0, 4'h0, 32'h0);
    drive(1, 32'hFFFF_FFFC, 0, 4'h0, 32'h0);
    drive(0, 32'h0000_4000, 0, 4'h0, 32'h0);
    drive(0, 32'h0000_3FFC, 0, 4'h0, 32'h0);
    drive(1, 32'h0001_1FFC, 1, 4'hF, 32'h0BAD_F00D);
    drive(1, 32'h0001_1FFC, 0, 4'h0, 32'h0);
    drive(0, 32'h0001_1FFC, 0, 4'h0, 32'h0);
    drive(1, 32'h0001_0010, 1, 4'h0, 32'hFFFF_FFFF);
    drive(1, 32'h0000_3FFC, 0, 4'h0, 32'h0);
    drain();

    // Mixed traffic.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a = RAM_BASE + (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a + 32'd1;
      if ($urandom_range(0, 2) == 0) drive(0, 32'($urandom_range(0, 255)) << 2, 0, 4'h0, 32'h0);
      else drive(1, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    drain();
    bad = 0;
    for (int i = 0; i < 2048; i++) if (ram_mem[i] !== exp_ram[i]) bad++;
    chk("ram_image", bad, 32'd0);

    // Reset in the RMW read cycle of a partial store.
    d_req_valid = 1; d_addr = 32'h0001_000C; d_we = 1; d_be = 4'b0100; d_wdata = 32'h00FF_0000;
    begin
      int n = 0;
      while (!d_req_ready && n < 50) begin @(negedge clk); n++; end
      chk("rst_hs", {31'b0, d_req_ready}, 32'd1);
    end
    @(posedge clk); #1;
    d_req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_mid_wen", {31'b0, ram_w_en}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 0;
    fork
      drive(1, 32'h0001_000C, 0, 4'h0, 32'h0);
      drive(0, 32'h0000_0010, 0, 4'h0, 32'h0);
      begin
        @(negedge clk);
        chk("post_rst_tie", {30'b0, d_req_ready, if_req_ready}, 32'b10);
      end
    join
    drain();
    chk("rst_mid_ram", ram_mem[3], 32'hACAC_ACAC);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the core's instruction-fetch port and its load/store port, and the two memory stores.
- The two stores are the word-read ROM, holding the program image, and the byte-addressed RAM, which takes 4-byte writes.
- Provides one unified, decoded address space and arbitrates between the two requesters.
- Serialises accesses one at a time.
- Implements byte-masked stores as read-modify-write, because the RAM only writes full 4-byte words.

Parameters:
- ROM_SZ, 16384, ROM size in bytes; ROM region is [0, ROM_SZ).
- RAM_BASE, 32'h0001_0000, byte address of RAM region start.
- RAM_SZ, 8192, RAM size in bytes; RAM region is [RAM_BASE, RAM_BASE+RAM_SZ).

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_resp_valid  out  1  one-cycle fetch response pulse
- if_rdata  out  32  fetch data
- if_err  out  1  fetch error, qualified by if_resp_valid
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables; bit i covers bits [8i+7:8i]
- d_wdata  in  32  store data
- d_resp_valid  out  1  one-cycle data response pulse
- d_rdata  out  32  load data
- d_err  out  1  data error, qualified by d_resp_valid
- rom_addr  out  32  ROM byte address
- rom_rdata  in  32  ROM word, combinational from rom_addr
- ram_addr  out  32  RAM byte offset, equal to addr - RAM_BASE
- ram_w_en  out  1  RAM write strobe
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM word, combinational from ram_addr

Behaviour:

Reset:
- All outputs are 0, FSM goes to IDLE, last_grant = IF.
- Reset mid-operation discards the in-flight request: no response, and ram_w_en is 0 from the reset cycle on.

FSM states:
- IDLE: readies asserted per grant. On handshake, latch requester id, addr, we, be, wdata, and an error flag.
  - err → RESP
  - load/fetch → ACCESS
  - store with be=4'hF → WRITE
  - store with be=4'h0 → RESP (no memory activity, err=0)
  - any other store → RMW_RD
- ACCESS: drive the latched address to the ROM or RAM. Register the selected rdata. → RESP
- RMW_RD: drive ram_addr. Merged word = ram_rdata with the bytes where be=1 replaced from wdata. Register it. → WRITE
- WRITE: ram_w_en=1 for exactly this cycle, with the merged or full word. → RESP
- RESP: assert the granted requester's resp_valid for exactly one cycle, with rdata and err. → IDLE

Latency, measured from the handshake cycle T:
- Load/fetch: resp at T+2.
- Full-word store: resp at T+2.
- Partial store: resp at T+3.
- Error: resp at T+1.

Arbitration and handshake:
- Only in IDLE. At most one ready is high per cycle; the ready is combinational from valid and last_grant.
- Both valid: grant the requester that is not last_grant. last_grant updates on each handshake.
- After reset, a tie goes to data.
- Responses cannot be back-pressured.
- Requesters hold valid and payload stable until ready. A new request is accepted no earlier than the cycle after RESP.

Errors (err=1, rdata=0, memory untouched):
- addr[1:0] != 0.
- addr in neither region.
- Store to the ROM region.
- Fetch from the RAM region is legal.
- Region checks use addr+3 < region end, computed 33-bit so there is no wrap at 32'hFFFF_FFFC.

Output defaults:
- Outside ACCESS/RMW_RD/WRITE, rom_addr, ram_addr and ram_wdata hold their last value.
- ram_w_en is 0 in every state except WRITE.
- rdata and err outputs hold their value between responses.

Test Plan:
1. Reset, then fetch 0x0000_0010 with rom_rdata=32'h0050_0093 → if_req_ready at T, if_resp_valid at T+2, if_rdata=32'h0050_0093, if_err=0.
2. Store 0x0001_0004, be=4'hF, wdata=32'hDEAD_BEEF → ram_w_en pulse at T+1 with ram_addr=4, d_resp_valid at T+2. A following load of the same address returns 32'hDEAD_BEEF.
3. RAM word 32'hACAC_ACAC at offset 8, store be=4'b0010, wdata=32'h0000_5500 → RMW read at T+1, ram_wdata=32'hACAC_55AC at T+2, resp at T+3.
4. Both valid for 6 cycles after reset, each re-requesting immediately → grants D, IF, D, IF. Never both readies high. Each response goes only to its requester.
5. Store to 0x0000_0100, load from 0x0001_0002, load from 0x0001_2000 → each gives err=1, rdata=0, resp at T+1, ram_w_en never high.
6. Assert rst in the WRITE-preceding RMW_RD cycle → no ram_w_en, no resp. After release, both readies follow the post-reset tie rule.
